// File: rtl/psdifir_pkg.sv
// psdifir_pkg: shared definitions for the multichannel FIR MAC engine.
//   - FSM state encoding used by psdifir_mcmac
//   - clog2 helper and accumulator width derivation
//   - default sample / coefficient widths
package psdifir_pkg;

  localparam int DEF_DW = 18;
  localparam int DEF_CW = 36;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_STORE = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  // Headroom for NTAPS full-scale products without wrapping.
  function automatic int acc_width(input int dw, input int cw, input int ntaps);
    return dw + cw + clog2(ntaps);
  endfunction

endpackage

// File: rtl/psdifir_lane_mac.sv
// psdifir_lane_mac: LANES signed multipliers followed by a registered adder
// tree. Fixed latency of 2 cycles from (data, coefs, vld) to (sum, sum_vld).
// Ports:
//   clk, rst      clock / asynchronous active-high reset (valid flags only)
//   vld           input word pair is valid this cycle
//   data          LANES packed signed samples, lane j at [j*DW +: DW]
//   coefs         LANES packed signed coefficients, lane j at [j*CW +: CW]
//   sum           sum of the LANES pairwise products
//   sum_vld       sum is valid this cycle
module psdifir_lane_mac
  import psdifir_pkg::*;
#(
  parameter int LANES = 8,
  parameter int DW    = DEF_DW,
  parameter int CW    = DEF_CW,
  parameter int SW    = DW + CW + clog2(LANES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vld,
  input  logic [LANES*DW-1:0]  data,
  input  logic [LANES*CW-1:0]  coefs,
  output logic signed [SW-1:0] sum,
  output logic                 sum_vld
);

  logic signed [DW+CW-1:0] prod_p0 [LANES];
  logic                    vld_p0;
  logic signed [SW-1:0]    tree_sum;

  // Stage p0: registered pairwise products
  always_ff @(posedge clk) begin
    for (int j = 0; j < LANES; j++)
      prod_p0[j] <= $signed(data[j*DW +: DW]) * $signed(coefs[j*CW +: CW]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= vld;
  end

  always_comb begin
    tree_sum = '0;
    for (int j = 0; j < LANES; j++)
      tree_sum = tree_sum + SW'(prod_p0[j]);
  end

  // Stage p1: registered adder tree output
  always_ff @(posedge clk) begin
    sum <= tree_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_vld <= 1'b0;
    else     sum_vld <= vld_p0;
  end

endmodule

// File: rtl/psdifir_mcmac.sv
// psdifir_mcmac: multichannel FIR multiply-accumulate engine. One LANES-wide
// MAC is time-shared over NCH channels; each frame sweeps every channel's
// buffer/coefficient memories once, rounds (half up) and shifts each result,
// and publishes all channels together with a one-cycle dataout_ready pulse.
// Build option: define PSDIFIR_SAT_EN to clamp results to the DW-bit signed
// range; otherwise results wrap to the low DW bits.
// Ports:
//   clockext100MHz  clock (posedge)          reset          async, active-high
//   datain_ready    new frame available      busy           frame in progress
//   chan_sel        channel being addressed  overrun        sticky frame-while-busy
//   addr_data       buffer word index        datain         buffer word (RD_LAT later)
//   addr_coefs      coefficient word index   coefs_in       coef word (RD_LAT later)
//   dataout         channel c at [c*DW +: DW]  dataout_ready  one-cycle update pulse
module psdifir_mcmac
  import psdifir_pkg::*;
#(
  parameter int NTAPS  = 2048,
  parameter int LANES  = 8,
  parameter int NCH    = 2,
  parameter int DW     = DEF_DW,
  parameter int CW     = DEF_CW,
  parameter int RD_LAT = 1,
  parameter int OSHIFT = 35,
  localparam int NWORDS = NTAPS / LANES,
  // Kept at least 1 bit wide so single-word / single-channel builds elaborate.
  localparam int AW     = (clog2(NWORDS) < 1) ? 1 : clog2(NWORDS),
  localparam int CHW    = (clog2(NCH) < 1) ? 1 : clog2(NCH),
  localparam int ACCW   = acc_width(DW, CW, NTAPS)
) (
  input  logic                clockext100MHz,
  input  logic                reset,
  input  logic                datain_ready,
  output logic [CHW-1:0]      chan_sel,
  output logic [AW-1:0]       addr_data,
  input  logic [LANES*DW-1:0] datain,
  output logic [AW-1:0]       addr_coefs,
  input  logic [LANES*CW-1:0] coefs_in,
  output logic [NCH*DW-1:0]   dataout,
  output logic                dataout_ready,
  output logic                busy,
  output logic                overrun
);

  localparam int SW = DW + CW + clog2(LANES);
  localparam int RW = ACCW + 1;  // one guard bit for the rounding add
  localparam logic signed [RW-1:0] RND = RW'(1) <<< (OSHIFT - 1);
`ifdef PSDIFIR_SAT_EN
  localparam logic signed [RW-1:0] SMAX = RW'((2 ** (DW - 1)) - 1);
  localparam logic signed [RW-1:0] SMIN = ~SMAX;
`endif

  state_t               state, state_nxt;
  logic [AW-1:0]        k;
  logic [CHW-1:0]       chan;
  logic [2:0]           dcnt;
  logic                 issue, store, last_chan, k_last;
  logic [RD_LAT-1:0]    vld_rd;
  logic signed [SW-1:0] mac_sum;
  logic                 mac_vld;
  logic signed [ACCW-1:0] acc;
  logic signed [DW-1:0] shadow [NCH];
  logic signed [DW-1:0] out_val;

  function automatic logic signed [RW-1:0] round_shift(input logic signed [ACCW-1:0] a);
    logic signed [RW-1:0] t;
    t = RW'(a) + RND;
    return t >>> OSHIFT;
  endfunction

  function automatic logic signed [DW-1:0] limit(input logic signed [RW-1:0] r);
`ifdef PSDIFIR_SAT_EN
    if (r > SMAX)      return SMAX[DW-1:0];
    else if (r < SMIN) return SMIN[DW-1:0];
    else               return r[DW-1:0];
`else
    return r[DW-1:0];
`endif
  endfunction

  assign last_chan  = (chan == CHW'(NCH - 1));
  assign k_last     = (k == AW'(NWORDS - 1));
  assign chan_sel   = chan;
  assign addr_data  = k;
  assign addr_coefs = k;
  assign out_val    = limit(round_shift(acc));

  always_ff @(posedge clockext100MHz or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (datain_ready) state_nxt = ST_ISSUE;
      ST_ISSUE: if (k_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (dcnt == 3'(RD_LAT + 1)) state_nxt = ST_STORE;
      ST_STORE: state_nxt = last_chan ? ST_IDLE : ST_ISSUE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != ST_IDLE);
    issue = (state == ST_ISSUE);
    store = (state == ST_STORE);
  end

  // k returns to 0 as soon as a sweep ends, so addresses read 0 outside ISSUE.
  always_ff @(posedge clockext100MHz or posedge reset) begin
    if (reset) begin
      k       <= '0;
      chan    <= '0;
      dcnt    <= '0;
      overrun <= 1'b0;
    end else begin
      k    <= (issue && !k_last) ? k + 1'b1 : '0;
      dcnt <= (state == ST_DRAIN) ? dcnt + 1'b1 : '0;
      if (store) chan <= last_chan ? '0 : chan + 1'b1;
      if (busy && datain_ready) overrun <= 1'b1;
    end
  end

  // Memory read stage: valid follows the issued address by RD_LAT cycles
  always_ff @(posedge clockext100MHz or posedge reset) begin
    if (reset) vld_rd <= '0;
    else begin
      vld_rd[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) vld_rd[i] <= vld_rd[i-1];
    end
  end

  psdifir_lane_mac #(
    .LANES(LANES), .DW(DW), .CW(CW), .SW(SW)
  ) u_lane_mac (
    .clk    (clockext100MHz),
    .rst    (reset),
    .vld    (vld_rd[RD_LAT-1]),
    .data   (datain),
    .coefs  (coefs_in),
    .sum    (mac_sum),
    .sum_vld(mac_vld)
  );

  // Accumulate / store stage: STORE sees the fully drained accumulator
  always_ff @(posedge clockext100MHz or posedge reset) begin
    if (reset) begin
      acc           <= '0;
      dataout       <= '0;
      dataout_ready <= 1'b0;
      for (int c = 0; c < NCH; c++) shadow[c] <= '0;
    end else begin
      dataout_ready <= store && last_chan;
      if (store) begin
        acc          <= '0;
        shadow[chan] <= out_val;
      end else if (mac_vld) begin
        acc <= acc + ACCW'(mac_sum);
      end
      // The last channel's shadow is written on this same edge, so bypass it.
      if (store && last_chan)
        for (int c = 0; c < NCH; c++)
          dataout[c*DW +: DW] <= (CHW'(c) == chan) ? out_val : shadow[c];
    end
  end

endmodule

// File: tb/tb_psdifir_mcmac.sv
// Self-checking bench for psdifir_mcmac (NTAPS=16, LANES=8, NCH=2, CW=40).
// A behavioural model computes each channel's dot product directly from the
// sample history and coefficient arrays and tracks frame timing by counting
// cycles; a compare process checks DUT outputs against it every cycle.
module tb_psdifir_mcmac;
  localparam int NTAPS = 16, LANES = 8, NCH = 2, DW = 18, CW = 40;
  localparam int RD_LAT = 1, OSHIFT = 35;
  localparam int NWORDS = NTAPS / LANES, AW = 1, CHW = 1;
  localparam int SEG = NWORDS + RD_LAT + 3, F = NCH * SEG;
  localparam longint ONE = 64'sd1 <<< OSHIFT;

  logic                clk, reset, datain_ready;
  logic [CHW-1:0]      chan_sel;
  logic [AW-1:0]       addr_data, addr_coefs;
  logic [LANES*DW-1:0] datain;
  logic [LANES*CW-1:0] coefs_in;
  logic [NCH*DW-1:0]   dataout;
  logic                dataout_ready, busy, overrun;

  psdifir_mcmac #(
    .NTAPS(NTAPS), .LANES(LANES), .NCH(NCH), .DW(DW), .CW(CW),
    .RD_LAT(RD_LAT), .OSHIFT(OSHIFT)
  ) dut (
    .clockext100MHz(clk), .reset(reset), .datain_ready(datain_ready),
    .chan_sel(chan_sel), .addr_data(addr_data), .datain(datain),
    .addr_coefs(addr_coefs), .coefs_in(coefs_in), .dataout(dataout),
    .dataout_ready(dataout_ready), .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // hist[c][d] = x[n-d] for channel c; coef[c][i] = h[i]
  logic signed [DW-1:0] hist [NCH][NTAPS];
  logic signed [CW-1:0] coef [NCH][NTAPS];

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chks(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic longint dout(input int c);
    return longint'($signed(dataout[c*DW +: DW]));
  endfunction

  // Memory model: words assembled from the history / coefficient arrays
  function automatic logic [LANES*DW-1:0] dword(input int ch, input int k);
    logic [LANES*DW-1:0] w;
    for (int j = 0; j < LANES; j++) w[j*DW +: DW] = hist[ch][LANES*k + LANES-1-j];
    return w;
  endfunction

  function automatic logic [LANES*CW-1:0] cword(input int ch, input int k);
    logic [LANES*CW-1:0] w;
    for (int j = 0; j < LANES; j++) w[j*CW +: CW] = coef[ch][LANES*k + LANES-1-j];
    return w;
  endfunction

  logic [LANES*DW-1:0] dq [RD_LAT];
  logic [LANES*CW-1:0] cq [RD_LAT];
  always @(posedge clk) begin
    for (int i = RD_LAT-1; i > 0; i--) begin
      dq[i] <= dq[i-1];
      cq[i] <= cq[i-1];
    end
    dq[0] <= dword(int'(chan_sel), int'(addr_data));
    cq[0] <= cword(int'(chan_sel), int'(addr_coefs));
  end
  assign datain   = dq[RD_LAT-1];
  assign coefs_in = cq[RD_LAT-1];

  // Reference: full-precision dot product, round half up, then clamp or wrap
  function automatic logic signed [DW-1:0] model_out(input int c);
    longint acc, r;
    logic signed [DW-1:0] w;
    acc = 0;
    for (int i = 0; i < NTAPS; i++) acc += longint'(hist[c][i]) * longint'(coef[c][i]);
    r = (acc + (64'sd1 <<< (OSHIFT-1))) >>> OSHIFT;
    w = r[DW-1:0];
`ifdef PSDIFIR_SAT_EN
    if (r > 131071) w = 18'sd131071;
    else if (r < -131072) w = -18'sd131072;
`endif
    return w;
  endfunction

  // Frame-level model: a frame accepted while idle finishes F edges later
  logic                 m_busy = 0, m_pulse = 0, m_ovr = 0;
  int                   m_cnt = 0;
  logic signed [DW-1:0] m_pend [NCH];
  logic signed [DW-1:0] m_dout [NCH];
  initial for (int c = 0; c < NCH; c++) begin m_pend[c] = 0; m_dout[c] = 0; end

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_busy = 0; m_pulse = 0; m_ovr = 0; m_cnt = 0;
      for (int c = 0; c < NCH; c++) m_dout[c] = 0;
    end else begin
      m_pulse = 0;
      if (m_busy) begin
        if (datain_ready) m_ovr = 1;
        m_cnt++;
        if (m_cnt == F) begin
          m_busy = 0; m_pulse = 1;
          for (int c = 0; c < NCH; c++) m_dout[c] = m_pend[c];
        end
      end else if (datain_ready) begin
        m_busy = 1; m_cnt = 0;
        for (int c = 0; c < NCH; c++) m_pend[c] = model_out(c);
      end
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    logic [NCH*DW-1:0] expv;
    @(negedge clk);
    if (!reset) begin
      for (int c = 0; c < NCH; c++) expv[c*DW +: DW] = m_dout[c];
      chk("dataout_ready", 64'(dataout_ready), 64'(m_pulse));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("overrun", 64'(overrun), 64'(m_ovr));
      chk("dataout", 64'(dataout), 64'(expv));
      if (!m_busy) begin
        chk("idle_addr", 64'({chan_sel, addr_data, addr_coefs}), 64'(0));
      end else begin
        chk("chan_sel", 64'(chan_sel), 64'(m_cnt / SEG));
        if ((m_cnt % SEG) < NWORDS) begin
          chk("addr_data", 64'(addr_data), 64'(m_cnt % SEG));
          chk("addr_coefs", 64'(addr_coefs), 64'(m_cnt % SEG));
        end
      end
    end
  end

  task automatic push(input logic signed [DW-1:0] s0, input logic signed [DW-1:0] s1);
    for (int c = 0; c < NCH; c++)
      for (int i = NTAPS-1; i > 0; i--) hist[c][i] = hist[c][i-1];
    hist[0][0] = s0;
    hist[1][0] = s1;
  endtask

  task automatic clear_coefs();
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < NTAPS; i++) coef[c][i] = '0;
  endtask

  // Raise datain_ready for one cycle (optionally again at cycle extra_at) and
  // wait for the completion pulse; lat counts cycles from the request cycle.
  task automatic run_frame(input bit now, input int extra_at, output int lat);
    if (!now) @(negedge clk);
    datain_ready = 1'b1;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      datain_ready = (lat == extra_at);
      if (dataout_ready) break;
      if (lat >= 100) begin
        chks("frame_timeout", lat, F + 1);
        break;
      end
    end
    datain_ready = 1'b0;
  endtask

  function automatic logic signed [CW-1:0] rcoef();
    logic signed [63:0] t;
    t = $signed({$urandom, $urandom}) >>> $urandom_range(24, 50);
    return t[CW-1:0];
  endfunction

  initial begin
    int lat;
    bit seen;
    reset = 1'b1;
    datain_ready = 1'b0;
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < NTAPS; i++) hist[c][i] = '0;
    clear_coefs();
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ready", 64'(dataout_ready), 64'(0));
    chk("rst_overrun", 64'(overrun), 64'(0));
    chk("rst_dataout", 64'(dataout), 64'(0));
    chk("rst_addr", 64'({chan_sel, addr_data, addr_coefs}), 64'(0));
    reset = 1'b0;

    // Impulse through h[i] = i: output steps 1000*i, then 0
    for (int i = 0; i < NTAPS; i++) coef[0][i] = CW'(longint'(i) * ONE);
    for (int i = 0; i <= NTAPS; i++) begin
      push((i == 0) ? 18'sd1000 : 18'sd0, 18'sd0);
      run_frame(1'b0, -1, lat);
      chks($sformatf("impulse_%0d", i), dout(0), (i < NTAPS) ? 1000 * i : 0);
      chks($sformatf("impulse_ch1_%0d", i), dout(1), 0);
    end
    chks("latency_impulse", lat, F + 1);

    // Channel separation: 0.5 and -0.25 gains
    clear_coefs();
    coef[0][0] = CW'(64'sd1 <<< 34);
    coef[1][0] = CW'(-(64'sd1 <<< 33));
    push(18'sd8000, 18'sd8000);
    run_frame(1'b0, -1, lat);
    chks("latency_sep", lat, 13);
    chks("sep_ch0", dout(0), 4000);
    chks("sep_ch1", dout(1), -2000);

    // New frame requested in the completion cycle is accepted cleanly
    push(-18'sd8000, 18'sd8000);
    run_frame(1'b1, -1, lat);
    chks("latency_b2b", lat, 13);
    chks("b2b_ch0", dout(0), -4000);
    chks("b2b_ch1", dout(1), -2000);
    chk("b2b_no_overrun", 64'(overrun), 64'(0));

    // Full-scale inputs with unity coefficients
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < NTAPS; i++) coef[c][i] = CW'(ONE);
    for (int i = 0; i < NTAPS; i++) push(18'sd131071, -18'sd131072);
    run_frame(1'b0, -1, lat);
`ifdef PSDIFIR_SAT_EN
    chks("sat_pos", dout(0), 131071);
    chks("sat_neg", dout(1), -131072);
`else
    chks("wrap_pos", dout(0), -16);
    chks("wrap_neg", dout(1), 0);
`endif

    // Rounding half up: 1.5 -> 2, -1.5 -> -1
    clear_coefs();
    coef[0][0] = CW'(64'sd1 <<< 34);
    coef[1][0] = CW'(64'sd1 <<< 34);
    push(18'sd3, -18'sd3);
    run_frame(1'b0, -1, lat);
    chks("round_pos", dout(0), 2);
    chks("round_neg", dout(1), -1);

    // Second request mid-frame: flagged, first frame unaffected
    push(18'sd7, -18'sd7);
    run_frame(1'b0, 5, lat);
    chks("latency_overrun", lat, 13);
    chks("ovr_ch0", dout(0), 4);
    chks("ovr_ch1", dout(1), -3);
    chk("overrun_set", 64'(overrun), 64'(1));

    // Reset in the middle of a frame
    push(18'sd9, -18'sd9);
    @(negedge clk);
    datain_ready = 1'b1;
    @(negedge clk);
    datain_ready = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_ready", 64'(dataout_ready), 64'(0));
    chk("midrst_overrun", 64'(overrun), 64'(0));
    chk("midrst_dataout", 64'(dataout), 64'(0));
    chk("midrst_addr", 64'({chan_sel, addr_data, addr_coefs}), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (dataout_ready) seen = 1'b1;
    end
    chk("midrst_no_pulse", 64'(seen), 64'(0));
    run_frame(1'b0, -1, lat);
    chks("latency_after_rst", lat, 13);
    chks("after_rst_ch0", dout(0), 5);
    chks("after_rst_ch1", dout(1), -4);

    // Randomized frames checked by the per-cycle model
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 2) == 0 || f == 0)
        for (int c = 0; c < NCH; c++)
          for (int i = 0; i < NTAPS; i++) coef[c][i] = rcoef();
      push(DW'($urandom), DW'($urandom));
      run_frame(1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : -1, lat);
      chks("latency_rand", lat, F + 1);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
